// File: rtl/micro_sequencer_if.sv
// Sequencer-side bundle: microword fields, flags and handshake in,
// control-store index, status and performance counters out.
interface micro_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [7:0]       addr_in;
  logic             jmpc;
  logic             z_en;
  logic             z;
  logic [7:0]       opcode;
  logic [7:0]       mpc;
  logic             z_sel;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] ucycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, stall, addr_in, jmpc, z_en, z, opcode,
    input  mpc, z_sel, running, done, ucycle_cnt, instr_cnt
  );

  modport slave (
    input  start, stall, addr_in, jmpc, z_en, z, opcode,
    output mpc, z_sel, running, done, ucycle_cnt, instr_cnt
  );
endinterface

// File: rtl/micro_sequencer.sv
// Next-address sequencer: owns MPC and Z select for the 512-entry control
// store, with start/stall/done handshake and saturating cycle/dispatch counters.
module micro_sequencer #(
  parameter logic [7:0] RESET_MPC = 8'h00,
  parameter logic [7:0] END_ADDR  = 8'hAA,
  parameter int         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  micro_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_mpc, w_mpc_nxt;
  logic             r_zsel, w_zsel_nxt;
  logic [CNT_W-1:0] r_ucnt, w_ucnt_nxt;
  logic [CNT_W-1:0] r_icnt, w_icnt_nxt;
  logic             r_running, w_running_nxt;
  logic             r_done, w_done_nxt;

  logic [7:0]       w_tgt;
  logic             w_z_tgt;
  logic             w_adv;
  logic             w_restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_tgt     = bus.jmpc ? bus.opcode : bus.addr_in;
  assign w_z_tgt   = bus.z_en & bus.z;
  // Stall outranks both the advance and END detection.
  assign w_adv     = (r_state == S_RUN) && !bus.stall;
  assign w_restart = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mpc     <= RESET_MPC;
      r_zsel    <= 1'b0;
      r_ucnt    <= '0;
      r_icnt    <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mpc     <= w_mpc_nxt;
      r_zsel    <= w_zsel_nxt;
      r_ucnt    <= w_ucnt_nxt;
      r_icnt    <= w_icnt_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.stall)             w_state_nxt = S_STALL;
        else if (w_tgt == END_ADDR) w_state_nxt = S_DONE;
      end
      S_STALL: if (!bus.stall) w_state_nxt = S_RUN;
      S_DONE:  if (bus.start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mpc_nxt  = r_mpc;
    w_zsel_nxt = r_zsel;
    w_ucnt_nxt = r_ucnt;
    w_icnt_nxt = r_icnt;
    if (w_restart) begin
      w_mpc_nxt  = RESET_MPC;
      w_zsel_nxt = 1'b0;
      w_ucnt_nxt = '0;
      w_icnt_nxt = '0;
    end else if (w_adv) begin
      w_mpc_nxt  = w_tgt;
      w_zsel_nxt = w_z_tgt;
      w_ucnt_nxt = sat_inc(r_ucnt);
      if (bus.jmpc) w_icnt_nxt = sat_inc(r_icnt);
    end
    w_running_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STALL);
    w_done_nxt    = (w_state_nxt == S_DONE);
  end

  assign bus.mpc        = r_mpc;
  assign bus.z_sel      = r_zsel;
  assign bus.running    = r_running;
  assign bus.done       = r_done;
  assign bus.ucycle_cnt = r_ucnt;
  assign bus.instr_cnt  = r_icnt;

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address sequencer for the microprogrammed control unit. It owns the micro-program counter (MPC) and the Z select bit that together index the 512-entry control store. It computes each next address from the current microword's `Addr`, `JMPC` and `Z_EN` fields, the instruction-register opcode and the ALU zero flag. It also provides start/stall/done handshaking to the top level, plus two saturating performance counters.

## Interface
Parameters:
- `RESET_MPC`, 8'h00: MPC value loaded at reset and on every start (fetch/NOP row).
- `END_ADDR`, 8'hAA: MPC value that terminates processing.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  single clock. All state updates on posedge. The control store samples `{z_sel, mpc}` on negedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level. Sampled in IDLE or DONE to begin a run.
- `stall`  in  1  memory/datapath busy. Freezes sequencing while high.
- `addr_in`  in  8  `Addr` field of the current microword.
- `jmpc`  in  1  `JMPC` field. When 1, the next MPC is the opcode (dispatch).
- `z_en`  in  1  `Z_EN` field. When 1, the next row selection uses the Z flag.
- `z`  in  1  ALU zero flag.
- `opcode`  in  8  IR opcode byte.
- `mpc`  out  8  micro-program counter.
- `z_sel`  out  1  upper control-store index bit.
- `running`  out  1  high in RUN or STALL.
- `done`  out  1  high in DONE. Equivalent to the control unit's End_of_process.
- `ucycle_cnt`  out  CNT_W  count of advanced microcycles in the current run.
- `instr_cnt`  out  CNT_W  count of dispatches (`jmpc`=1 advances) in the current run.

## Operation
- States: IDLE, RUN, STALL, DONE.
- Next-address rule:
  - `nxt_mpc` = `jmpc` ? `opcode` : `addr_in`.
  - `nxt_z` = `z_en` ? `z` : 0.
- IDLE:
  - `mpc`=RESET_MPC, `z_sel`=0.
  - `start`=1 → RUN. Counters cleared on that edge. MPC does not advance on that edge.
- RUN, each posedge:
  - `stall`=1 → STALL. `mpc`, `z_sel` and counters are held.
  - Otherwise `mpc`←`nxt_mpc`, `z_sel`←`nxt_z`, and `ucycle_cnt`+1.
  - `instr_cnt`+1 if `jmpc`=1.
  - If `nxt_mpc`==END_ADDR, go to DONE on the same edge. The MPC still loads END_ADDR.
- STALL:
  - All held.
  - `stall`=0 → RUN. No advance on the exit edge; the first advance is on the following edge.
- DONE:
  - `mpc` holds END_ADDR and counters hold.
  - `start`=1 → RUN with `mpc`=RESET_MPC, `z_sel`=0, counters cleared, all on one edge.
  - `start`=0 → stays in DONE.
- Counters saturate at all-ones and never wrap.
- If `stall` and END detection coincide, stall has priority: state goes to STALL and no advance occurs.
- Priority in RUN: `stall` > advance/END. `start` is ignored in RUN and STALL.
- `z` is sampled only on the advancing edge. Changes to `z` while stalled have no effect until the advance.

## Timing
- Reset (async, immediate): `mpc`=RESET_MPC, `z_sel`=0, `running`=0, `done`=0, `ucycle_cnt`=0, `instr_cnt`=0, state IDLE.
- Reset mid-run aborts immediately. After deassertion the block waits in IDLE for `start`.
- `running` and `done` are registered outputs decoded from state, valid one posedge after the transition edge.
- Latency:
  - `start` high at edge N → `running`=1 after N.
  - First MPC advance at edge N+1.
- Microword fields `addr_in`/`jmpc`/`z_en` must be stable before posedge. They come from the negedge-loaded MIR, which gives a half-cycle setup.
- Minimum run: dispatch straight to END_ADDR takes 1 advancing edge; `done`=1 after it, with `ucycle_cnt`=1.

## Test plan
- Reset and start:
  - Assert `rst` mid-cycle → all outputs at reset values asynchronously.
  - Release, then pulse `start` → `running`=1 and `mpc`=8'h00.
- Dispatch:
  - `mpc`=00, `jmpc`=1, `opcode`=8'h01 → next `mpc`=01, `instr_cnt`=1.
  - Then `addr_in`=8'h11, `jmpc`=0 → `mpc`=11, `ucycle_cnt`=2.
- Z branch:
  - `z_en`=1, `addr_in`=8'h50, `z`=1 → `mpc`=50, `z_sel`=1.
  - Repeat with `z`=0 → `z_sel`=0.
  - `z_en`=0, `z`=1 → `z_sel`=0.
- Stall:
  - Hold `stall`=1 for 3 cycles while in RUN with `addr_in`=8'h22 → `mpc` and counters unchanged, `running`=1.
  - Release → `mpc`=22 two edges after release.
- End and restart:
  - `addr_in`=8'hAA → `mpc`=AA, `done`=1, `running`=0.
  - `start` → `mpc`=00, counters 0, state RUN.
  - Stall asserted on the END edge → no DONE until stall clears and the advance occurs.
- Saturation: with CNT_W=4, run 20 advances → `ucycle_cnt`=4'hF, held.
